// File: rtl/lm80c_sio_uart.sv
// Minimal 8N1 UART on the Z80 I/O bus with a small RX FIFO and optional interrupt.
// Define SIO_LOOPBACK_EN to implement the ctrl LOOP bit (internal TX->RX loopback).
`timescale 1ns/1ps
module lm80c_sio_uart #(
  parameter int BAUD_DIV = 217,
  parameter int RX_DEPTH = 4
) (
  input  logic       sys_clock,
  input  logic       RESET,
  input  logic       sel,
  input  logic [1:0] cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       int_n,
  output logic       txd,
  input  logic       rxd
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [AW:0]   FIFO_CAP  = (AW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus strobes: one write event and one read-end event per bus cycle
  logic       wr_lvl, rd_lvl, wr_prev_q, rd_prev_q, wr_ev, rd_end;
  logic [1:0] rd_cs_q;

  assign wr_lvl = sel & wr;
  assign rd_lvl = sel & rd;
  assign wr_ev  = wr_lvl & ~wr_prev_q;
  assign rd_end = rd_prev_q & ~rd_lvl;

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      rd_cs_q   <= 2'd0;
    end else begin
      wr_prev_q <= wr_lvl;
      rd_prev_q <= rd_lvl;
      if (rd_lvl) rd_cs_q <= cs;
    end
  end

  logic wr_tx, wr_ctrl, err_clr;
  assign wr_tx   = wr_ev && (cs == 2'd0);
  assign wr_ctrl = wr_ev && (cs == 2'd2);
  assign err_clr = wr_ev && (cs == 2'd3);

  logic [2:0] ctrl_q;

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      ctrl_q <= 3'd0;
    end else if (wr_ctrl) begin
`ifdef SIO_LOOPBACK_EN
      ctrl_q <= din[2:0];
`else
      ctrl_q <= {1'b0, din[1:0]};
`endif
    end
  end

  // TX: holding register feeding a 10-bit shifter {stop, data, start}
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       tx_busy_q;
  logic [9:0] tx_sh_q;
  logic [3:0] tx_bit_q;
  logic [CW-1:0] tx_cnt_q;
  logic       tx_line_q;
  logic       tx_bit_end, tx_frame_end, tx_load;

  assign tx_bit_end   = tx_busy_q && (tx_cnt_q == BAUD_LAST);
  assign tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);
  assign tx_load      = hold_full_q && (!tx_busy_q || tx_frame_end);

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      hold_full_q <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_bit_q    <= 4'd0;
      tx_cnt_q    <= '0;
      tx_line_q   <= 1'b1;
    end else begin
      if (tx_load) begin
        tx_busy_q   <= 1'b1;
        tx_bit_q    <= 4'd0;
        tx_cnt_q    <= '0;
        hold_full_q <= 1'b0;
      end else if (tx_frame_end) begin
        tx_busy_q <= 1'b0;
      end else if (tx_bit_end) begin
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_cnt_q <= '0;
      end else if (tx_busy_q) begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
      if (wr_tx && !hold_full_q) hold_full_q <= 1'b1;
      tx_line_q <= tx_busy_q ? tx_sh_q[0] : 1'b1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (wr_tx && !hold_full_q) hold_q <= din;
    if (tx_load)
      tx_sh_q <= {1'b1, hold_q, 1'b0};
    else if (tx_bit_end)
      tx_sh_q <= {1'b1, tx_sh_q[9:1]};
  end

  logic rx_src;
`ifdef SIO_LOOPBACK_EN
  assign rx_src = ctrl_q[2] ? tx_line_q : rxd;
  assign txd    = ctrl_q[2] ? 1'b1 : tx_line_q;
`else
  assign rx_src = rxd;
  assign txd    = tx_line_q;
`endif

  // Synchroniser resets low so a frame already under way at reset release
  // cannot produce a falling edge until the line has been seen high.
  logic rx_sync_q, rx_s_q, rx_prev_q, rx_fall;

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      rx_sync_q <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_sync_q <= rx_src;
      rx_s_q    <= rx_sync_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_tick, rx_push, rx_set_fe, rx_set_ovr;

  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty, fifo_full, fifo_pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_CAP);
  assign fifo_pop   = rd_end && (rd_cs_q == 2'd0) && !fifo_empty;
  assign rx_tick    = (rx_cnt_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_set_fe  = 1'b0;
    rx_set_ovr = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = BAUD_HALF;
        end
      end
      RX_START: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else if (rx_s_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = BAUD_LAST;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
          rx_cnt_d = BAUD_LAST;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_state_d = RX_IDLE;
          if (!rx_s_q)                      rx_set_fe  = 1'b1;
          else if (fifo_full && !fifo_pop)  rx_set_ovr = 1'b1;
          else                              rx_push    = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_ff @(posedge sys_clock) begin
    rx_sh_q <= rx_sh_d;
    if (rx_push) fifo_mem[wr_ptr_q] <= rx_sh_q;
  end

  // Simultaneous push and pop are both honoured; count is then unchanged
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rx_push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({rx_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic fe_q, ovr_q, int_n_q;
  logic [7:0] status;

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      if (err_clr) begin
        fe_q  <= 1'b0;
        ovr_q <= 1'b0;
      end
      if (rx_set_fe)  fe_q  <= 1'b1;
      if (rx_set_ovr) ovr_q <= 1'b1;
      int_n_q <= ~((ctrl_q[0] & ~fifo_empty) | (ctrl_q[1] & ~hold_full_q));
    end
  end

  assign int_n  = int_n_q;
  assign status = {3'b000, tx_busy_q, fe_q, ovr_q, ~hold_full_q, ~fifo_empty};

  always_comb begin
    dout = 8'h00;
    case (cs)
      2'd0:    dout = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
      2'd1:    dout = status;
      2'd2:    dout = {5'b00000, ctrl_q};
      default: dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_lm80c_sio_uart.sv
// Self-checking bench for lm80c_sio_uart: register table, TX/RX scoreboards and corner sequences.
`timescale 1ns/1ps
module tb_lm80c_sio_uart;
  localparam int BAUD = 8;

  logic       clk = 1'b0;
  logic       rst, sel, rd, wr, rxd;
  logic [1:0] cs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       int_n, txd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       mon_en = 1'b1;
  logic [7:0] mon_b;
  logic       mon_st, mon_sp, mon_en_f;
  logic       poll_seen;

  typedef struct {
    bit         is_wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  lm80c_sio_uart #(.BAUD_DIV(BAUD), .RX_DEPTH(4)) dut (
    .sys_clock(clk), .RESET(rst), .sel(sel), .cs(cs), .rd(rd), .wr(wr),
    .din(din), .dout(dout), .int_n(int_n), .txd(txd), .rxd(rxd)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] c, input logic [7:0] d);
    sel = 1'b1; cs = c; din = d; wr = 1'b1;
    tick(2);
    wr = 1'b0; sel = 1'b0;
    tick(1);
  endtask

  task automatic bus_read(input logic [1:0] c, input logic [7:0] exp, input int n, input string name);
    sel = 1'b1; cs = c; rd = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check(name, dout, exp);
    end
    @(posedge clk); #1;
    rd = 1'b0; sel = 1'b0;
    tick(1);
  endtask

  task automatic read_fifo(input string name);
    if (rxq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: rx scoreboard empty, got nothing to compare, expected a byte", name);
    end else begin
      bus_read(2'd0, rxq.pop_front(), 4, name);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd = 1'b0; tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i]; tick(BAUD);
    end
    rxd = stop; tick(BAUD);
    rxd = 1'b1; tick(4);
  endtask

  // TX monitor: decodes frames on txd at mid-bit and compares against the TX scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        mon_en_f = mon_en;
        repeat (3) @(negedge clk);
        mon_st = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          mon_b[i] = txd;
        end
        repeat (BAUD) @(negedge clk);
        mon_sp = txd;
        if (mon_en_f) begin
          if (txq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL tx_unexpected: got frame 0x%02h, expected no frame", mon_b);
          end else begin
            check("tx_byte", mon_b, txq.pop_front());
            check("tx_start_stop", {6'd0, mon_st, mon_sp}, 8'h01);
          end
        end
      end
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; cs = 2'd0; din = 8'h00; rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    check("rst_int_n", {7'd0, int_n}, 8'h01);
    check("rst_txd", {7'd0, txd}, 8'h01);

    vt[0] = '{1'b0, 2'd1, 8'h00, 8'h02};
    vt[1] = '{1'b0, 2'd0, 8'h00, 8'h00};
    vt[2] = '{1'b0, 2'd3, 8'h00, 8'hFF};
    vt[3] = '{1'b0, 2'd2, 8'h00, 8'h00};
    vt[4] = '{1'b1, 2'd2, 8'hF8, 8'h00};
    vt[5] = '{1'b0, 2'd2, 8'h00, 8'h00};
`ifdef SIO_LOOPBACK_EN
    vt[5].exp = 8'h00;
`endif
    vt[6] = '{1'b1, 2'd1, 8'hFF, 8'h00};
    vt[7] = '{1'b0, 2'd1, 8'h00, 8'h02};
    vt[8] = '{1'b1, 2'd2, 8'h01, 8'h00};
    vt[9] = '{1'b0, 2'd2, 8'h00, 8'h01};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_wr) bus_write(vt[i].a, vt[i].d);
      else bus_read(vt[i].a, vt[i].exp, 2, $sformatf("vec%0d", i));
    end
    bus_write(2'd2, 8'h00);

    // TX timing: start bit appears two clocks after the write event
    tick(1);
    sel = 1'b1; cs = 2'd0; din = 8'hA5; wr = 1'b1;
    txq.push_back(8'hA5);
    tick(2);
    check("tx_pre_start", {7'd0, txd}, 8'h01);
    wr = 1'b0; sel = 1'b0;
    tick(1);
    check("tx_start_low", {7'd0, txd}, 8'h00);
    tick(7);
    check("tx_start_len", {7'd0, txd}, 8'h00);
    tick(1);
    check("tx_d0", {7'd0, txd}, 8'h01);
    bus_read(2'd1, 8'h12, 2, "stat_tx_mid");
    tick(100);
    bus_read(2'd1, 8'h02, 2, "stat_tx_done");

    // Back-to-back TX; third write hits a full holding register and is dropped
    bus_write(2'd0, 8'h11); txq.push_back(8'h11);
    bus_write(2'd0, 8'h22); txq.push_back(8'h22);
    bus_write(2'd0, 8'h33);
    bus_read(2'd1, 8'h10, 2, "stat_hold_full");
    tick(200);
    bus_read(2'd1, 8'h02, 2, "stat_b2b_done");
    check("tx_drained", 8'(txq.size()), 8'h00);

    // RX single frame
    send_rx(8'h3C, 1'b1); rxq.push_back(8'h3C);
    bus_read(2'd1, 8'h03, 2, "stat_rxa");
    read_fifo("rx_3c");
    bus_read(2'd1, 8'h02, 2, "stat_after_pop");

    // Overflow: fifth frame is discarded
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i), 1'b1);
      if (i <= 4) rxq.push_back(8'(i));
    end
    bus_read(2'd1, 8'h07, 2, "stat_ovr");
    for (int i = 0; i < 4; i++) read_fifo($sformatf("rx_ovr%0d", i));
    bus_read(2'd1, 8'h06, 2, "stat_ovr_empty");
    bus_write(2'd3, 8'h00);
    bus_read(2'd1, 8'h02, 2, "stat_ovr_clr");

    // Framing error leaves FIFO contents untouched; a short glitch is ignored
    send_rx(8'h5A, 1'b1); rxq.push_back(8'h5A);
    send_rx(8'h00, 1'b0);
    bus_read(2'd1, 8'h0B, 2, "stat_fe");
    read_fifo("rx_5a");
    bus_read(2'd1, 8'h0A, 2, "stat_fe_empty");
    bus_write(2'd3, 8'h5A);
    bus_read(2'd1, 8'h02, 2, "stat_fe_clr");
    rxd = 1'b0; tick(2); rxd = 1'b1;
    tick(30);
    bus_read(2'd1, 8'h02, 2, "stat_glitch");

    // RX interrupt: int_n follows RXA with one clock of lag
    bus_write(2'd2, 8'h01);
    cs = 2'd1;
    poll_seen = 1'b0;
    fork
      begin
        send_rx(8'h55, 1'b1);
      end
      begin
        for (int i = 0; i < 200 && !poll_seen; i++) begin
          @(negedge clk);
          if (dout[0]) begin
            poll_seen = 1'b1;
            check("int_lag", {7'd0, int_n}, 8'h01);
            @(negedge clk);
            check("int_assert", {7'd0, int_n}, 8'h00);
          end
        end
      end
    join
    rxq.push_back(8'h55);
    if (!poll_seen) begin
      n_checks++; n_fail++;
      $display("FAIL int_timeout: got no RXA within 200 clocks, expected RXA");
    end
    read_fifo("rx_55");
    check("int_hold", {7'd0, int_n}, 8'h00);
    tick(1);
    check("int_release", {7'd0, int_n}, 8'h01);

    // TX interrupt from an empty holding register
    bus_write(2'd2, 8'h02);
    check("int_the", {7'd0, int_n}, 8'h00);
    bus_write(2'd2, 8'h00);
    check("int_off", {7'd0, int_n}, 8'h01);

`ifdef SIO_LOOPBACK_EN
    bus_write(2'd2, 8'h04);
    bus_read(2'd2, 8'h04, 2, "ctrl_loop");
    bus_write(2'd0, 8'h81); rxq.push_back(8'h81);
    poll_seen = 1'b0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) poll_seen = 1'b1;
    end
    check("loop_txd_idle", {7'd0, poll_seen}, 8'h00);
    tick(1);
    bus_read(2'd1, 8'h03, 2, "stat_loop");
    read_fifo("rx_loop");
    bus_write(2'd2, 8'h00);
`endif

    // Mid-frame reset: TX aborts, a partially received RX frame is ignored
    mon_en = 1'b0;
    bus_write(2'd0, 8'h00);
    fork
      send_rx(8'h00, 1'b1);
      begin
        tick(17);
        check("rst_pre_txd", {7'd0, txd}, 8'h00);
        rst = 1'b1;
        tick(1);
        check("rst_mid_txd", {7'd0, txd}, 8'h01);
        rst = 1'b0;
      end
    join
    tick(20);
    mon_en = 1'b1;
    bus_read(2'd1, 8'h02, 2, "stat_after_rst");
    send_rx(8'hC3, 1'b1); rxq.push_back(8'hC3);
    read_fifo("rx_c3");
    bus_read(2'd1, 8'h02, 2, "stat_final");

    check("rx_sb_drained", 8'(rxq.size()), 8'h00);
    check("tx_sb_drained", 8'(txq.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
